// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encoding and FSM states.
package univ_shift_reg_pkg;

  localparam logic [1:0] MODE_SHL = 2'b00;
  localparam logic [1:0] MODE_SHR = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/dff_en.sv
// Parameterised-width D flip-flop with load enable and asynchronous active-low reset to zero.
module dff_en #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus multi-cycle shift/rotate driven by an IDLE/SHIFT/DONE FSM.
// Define UNIV_SHIFT_REG_ARITH_EN to make mode 01 an arithmetic (sign-filling) right shift.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [CNT_W-1:0] Count,
  input  logic             SerIn,
  output logic [WIDTH-1:0] Q,
  output logic             SerOut,
  output logic             Busy,
  output logic             Done
);

  import univ_shift_reg_pkg::*;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             serout_q, serout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             q_en, cnt_en;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] shift_val;
  logic             shift_out;
  logic             shr_fill;

  dff_en #(.WIDTH(WIDTH)) u_q_reg (
    .clk   (Clk),
    .rst_n (Resetn),
    .en    (q_en),
    .d     (q_d),
    .q     (q_q)
  );

  dff_en #(.WIDTH(CNT_W)) u_cnt_reg (
    .clk   (Clk),
    .rst_n (Resetn),
    .en    (cnt_en),
    .d     (cnt_d),
    .q     (cnt_q)
  );

`ifdef UNIV_SHIFT_REG_ARITH_EN
  assign shr_fill = q_q[WIDTH-1];
`else
  assign shr_fill = SerIn;
`endif

  // One-bit step for the mode latched at Start; the bit leaving the register also feeds SerOut.
  always_comb begin
    shift_val = {q_q[WIDTH-2:0], SerIn};
    shift_out = q_q[WIDTH-1];
    case (mode_q)
      MODE_SHL: begin
        shift_val = {q_q[WIDTH-2:0], SerIn};
        shift_out = q_q[WIDTH-1];
      end
      MODE_SHR: begin
        shift_val = {shr_fill, q_q[WIDTH-1:1]};
        shift_out = q_q[0];
      end
      MODE_ROL: begin
        shift_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        shift_out = q_q[WIDTH-1];
      end
      MODE_ROR: begin
        shift_val = {q_q[0], q_q[WIDTH-1:1]};
        shift_out = q_q[0];
      end
      default: ;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    serout_d = serout_q;
    q_en     = 1'b0;
    q_d      = q_q;
    cnt_en   = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (Load) begin
          q_en = 1'b1;
          q_d  = D;
        end else if (Start) begin
          if (Count != '0) begin
            mode_d  = Mode;
            cnt_en  = 1'b1;
            cnt_d   = Count;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        q_en     = 1'b1;
        q_d      = shift_val;
        serout_d = shift_out;
        cnt_en   = 1'b1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the state being entered.
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_SHL;
      serout_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      serout_q <= serout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Q      = q_q;
  assign SerOut = serout_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4).
module tb_univ_shift_reg;

  logic       Clk;
  logic       Resetn;
  logic       Load;
  logic [7:0] D;
  logic       Start;
  logic [1:0] Mode;
  logic [3:0] Count;
  logic       SerIn;
  logic [7:0] Q;
  logic       SerOut;
  logic       Busy;
  logic       Done;

  int n_tests = 0;
  int n_fail  = 0;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .Load   (Load),
    .D      (D),
    .Start  (Start),
    .Mode   (Mode),
    .Count  (Count),
    .SerIn  (SerIn),
    .Q      (Q),
    .SerOut (SerOut),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic load_val(input logic [7:0] val);
    Load = 1'b1;
    D    = val;
    step();
    Load = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] m, input logic [3:0] c, input logic si);
    Start = 1'b1;
    Mode  = m;
    Count = c;
    SerIn = si;
    step();
    Start = 1'b0;
  endtask

  logic [7:0] shl_q   [3] = '{8'h4B, 8'h97, 8'h2F};
  logic       shl_so  [3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] ror_q   [4] = '{8'hC0, 8'h60, 8'h30, 8'h18};
  logic       ror_so  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0] arith_exp;
  int         done_seen;

  initial begin
    Resetn = 1'b0;
    Load   = 1'b0;
    D      = '0;
    Start  = 1'b0;
    Mode   = 2'b00;
    Count  = '0;
    SerIn  = 1'b0;
    step();
    check("rst_q", Q, 8'h00);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_serout", SerOut, 1'b0);
    Resetn = 1'b1;
    step();

    // Shift left A5 by 3 with SerIn=1.
    load_val(8'hA5);
    check("shl_load", Q, 8'hA5);
    start_op(2'b00, 4'd3, 1'b1);
    check("shl_start_q", Q, 8'hA5);
    check("shl_start_busy", Busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("shl_q%0d", i), Q, shl_q[i]);
      check($sformatf("shl_so%0d", i), SerOut, shl_so[i]);
      check($sformatf("shl_busy%0d", i), Busy, (i < 2) ? 1'b1 : 1'b0);
      check($sformatf("shl_done%0d", i), Done, (i == 2) ? 1'b1 : 1'b0);
    end
    step();
    check("shl_done_drop", Done, 1'b0);
    check("shl_idle_busy", Busy, 1'b0);

    // Rotate right 81 by 4.
    load_val(8'h81);
    start_op(2'b11, 4'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("ror_q%0d", i), Q, ror_q[i]);
      check($sformatf("ror_so%0d", i), SerOut, ror_so[i]);
    end
    check("ror_done", Done, 1'b1);
    step();
    check("ror_done_once", Done, 1'b0);

    // Count larger than WIDTH: rotate left 81 by 9 is a net rotate by 1.
    load_val(8'h81);
    start_op(2'b10, 4'd9, 1'b0);
    for (int i = 0; i < 8; i++) step();
    check("rol9_mid_q", Q, 8'h81);
    check("rol9_mid_busy", Busy, 1'b1);
    step();
    check("rol9_q", Q, 8'h03);
    check("rol9_done", Done, 1'b1);
    step();

    // Count of zero goes straight to DONE.
    load_val(8'h3C);
    start_op(2'b00, 4'd0, 1'b1);
    check("cnt0_busy", Busy, 1'b0);
    check("cnt0_done", Done, 1'b1);
    check("cnt0_q", Q, 8'h3C);
    step();
    check("cnt0_done_drop", Done, 1'b0);
    check("cnt0_busy2", Busy, 1'b0);

    // Load beats Start in IDLE.
    Load  = 1'b1;
    D     = 8'h5A;
    Start = 1'b1;
    Mode  = 2'b00;
    Count = 4'd3;
    step();
    Load  = 1'b0;
    Start = 1'b0;
    check("both_q", Q, 8'h5A);
    check("both_busy", Busy, 1'b0);
    step();
    check("both_busy2", Busy, 1'b0);
    check("both_done2", Done, 1'b0);

    // Inputs changed during SHIFT are ignored: 5A >> 2 with SerIn=0.
    start_op(2'b01, 4'd2, 1'b0);
    Load  = 1'b1;
    D     = 8'hFF;
    Start = 1'b1;
    Mode  = 2'b10;
    Count = 4'd7;
    step();
    step();
    Load  = 1'b0;
    Start = 1'b0;
    check("ign_q", Q, 8'h16);
    check("ign_done", Done, 1'b1);
    check("ign_so", SerOut, 1'b1);
    step();
    check("ign_idle_q", Q, 8'h16);

    // A load leaves SerOut untouched.
    load_val(8'h00);
    check("ld_q", Q, 8'h00);
    check("ld_so", SerOut, 1'b1);

    // Right shift of a negative value: sign fill only in the arithmetic build.
`ifdef UNIV_SHIFT_REG_ARITH_EN
    arith_exp = 8'hE4;
`else
    arith_exp = 8'h24;
`endif
    load_val(8'h90);
    start_op(2'b01, 4'd2, 1'b0);
    step();
    step();
    check("shr_q", Q, arith_exp);
    step();

    // Asynchronous reset in the second SHIFT cycle of a 5-shift operation.
    load_val(8'hA5);
    start_op(2'b00, 4'd5, 1'b0);
    step();
    check("rst_mid_pre_so", SerOut, 1'b1);
    Resetn = 1'b0;
    #1;
    check("rst_mid_q", Q, 8'h00);
    check("rst_mid_busy", Busy, 1'b0);
    check("rst_mid_done", Done, 1'b0);
    check("rst_mid_so", SerOut, 1'b0);
    step();
    Resetn    = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (Done) done_seen++;
    end
    check("rst_mid_no_done", done_seen, 0);
    check("rst_mid_idle_q", Q, 8'h00);
    load_val(8'h42);
    check("post_rst_load", Q, 8'h42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
